// File: rtl/cpu_bus_target_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_target_pkg
// Purpose  : Shared types and register map for CPU bus target peripherals.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_bus_target_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] REG_ID       = 4'd0;
    localparam logic [3:0] REG_SCRATCH  = 4'd1;
    localparam logic [3:0] REG_CYCLES   = 4'd2;
    localparam logic [3:0] REG_XFERS    = 4'd3;
    localparam logic [3:0] REG_GP_FIRST = 4'd4;

    localparam int NUM_REGS = 16;

endpackage
`default_nettype wire

// File: rtl/cpu_bus_target_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_target_if
// Purpose  : CPU external bus request/response bundle with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_bus_target_if;

    logic        i_bus_clk;
    logic        i_bus_we;
    logic [31:0] i_bus_addr;
    logic [31:0] i_bus_data;
    logic [31:0] o_bus_data;
    logic        o_bus_data_ready;
    logic        o_busy;

    modport master (
        output i_bus_clk, i_bus_we, i_bus_addr, i_bus_data,
        input  o_bus_data, o_bus_data_ready, o_busy
    );

    modport slave (
        input  i_bus_clk, i_bus_we, i_bus_addr, i_bus_data,
        output o_bus_data, o_bus_data_ready, o_busy
    );

endinterface
`default_nettype wire

// File: rtl/cpu_bus_target_bus_req_edge.sv
`default_nettype none
// ============================================================================
// Module   : bus_req_edge
// Purpose  : Request strobe history with rise/fall pulses for bus targets.
// Revision : 1.0 - initial release
// ============================================================================
module bus_req_edge (
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    input  wire logic i_req,
    output logic      o_rise,
    output logic      o_fall
);

    logic r_req_q;
    logic r_armed;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_q <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_req_q <= i_req;
            r_armed <= 1'b1;
        end
    end

    // Edges are masked for the first cycle after reset so a strobe already
    // high at release is not mistaken for a new request.
    assign o_rise = r_armed &  i_req & ~r_req_q;
    assign o_fall = r_armed & ~i_req &  r_req_q;

endmodule
`default_nettype wire

// File: rtl/cpu_bus_target.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_target
// Purpose  : Memory-mapped CPU bus responder with ID/scratch/counter/GP regs.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_target
    import cpu_bus_target_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned ADDR_LSB    = 0,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] ID_VALUE    = 32'h6583_2001
) (
    input  wire logic         i_cpu_clk,
    input  wire logic         i_rst_n,
    cpu_bus_target_if.slave   bus
);

    state_t      r_state;
    state_t      w_state_next;
    logic        w_rise;
    logic        w_fall_unused;
    logic        w_hit;
    logic        w_accept;
    logic        w_access;
    logic        w_wait_dec;
    logic        w_wr_en;
    logic [31:0] w_rd_val;

    logic        r_we;
    logic [3:0]  r_idx;
    logic [31:0] r_wdata;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_rdata;
    logic [31:0] r_cycles;
    logic [31:0] r_xfers;
    logic [31:0] r_regs [NUM_REGS];

    bus_req_edge u_edge (
        .i_clk   (i_cpu_clk),
        .i_rst_n (i_rst_n),
        .i_req   (bus.i_bus_clk),
        .o_rise  (w_rise),
        .o_fall  (w_fall_unused)
    );

    assign w_hit = (bus.i_bus_addr[31:ADDR_LSB+4] == BASE_ADDR[31:ADDR_LSB+4]);

    always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        w_wait_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise && w_hit) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A dropped strobe abandons the request before any side effect.
                if (!bus.i_bus_clk) begin
                    w_state_next = ST_IDLE;
                end else if (r_wait_cnt == 4'd0) begin
                    w_access     = 1'b1;
                    w_state_next = ST_RESP;
                end else begin
                    w_wait_dec   = 1'b1;
                end
            end
            ST_RESP: begin
                if (!bus.i_bus_clk) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign bus.o_bus_data_ready = (r_state == ST_RESP);
    assign bus.o_busy           = (r_state != ST_IDLE);
    assign bus.o_bus_data       = r_rdata;

    always_comb begin
        w_rd_val = r_regs[r_idx];
        case (r_idx)
            REG_ID:     w_rd_val = ID_VALUE;
            REG_CYCLES: w_rd_val = r_cycles;
            REG_XFERS:  w_rd_val = r_xfers;
            default:    w_rd_val = r_regs[r_idx];
        endcase
    end

    assign w_wr_en = w_access & r_we &
                     ((r_idx == REG_SCRATCH) || (r_idx >= REG_GP_FIRST));

    always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we       <= 1'b0;
            r_idx      <= 4'd0;
            r_wdata    <= 32'd0;
            r_wait_cnt <= 4'd0;
            r_rdata    <= 32'd0;
            r_cycles   <= 32'd0;
            r_xfers    <= 32'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            r_cycles <= r_cycles + 32'd1;

            if (w_accept) begin
                r_we       <= bus.i_bus_we;
                r_idx      <= bus.i_bus_addr[ADDR_LSB+3:ADDR_LSB];
                r_wdata    <= bus.i_bus_data;
                r_wait_cnt <= 4'(WAIT_STATES);
            end else if (w_wait_dec) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end

            if (w_access) begin
                // Writing XFERS clears it outright instead of counting itself.
                if (r_we && (r_idx == REG_XFERS)) begin
                    r_xfers <= 32'd0;
                end else begin
                    r_xfers <= r_xfers + 32'd1;
                end
                if (!r_we) begin
                    r_rdata <= w_rd_val;
                end
            end

            if (w_wr_en) begin
                r_regs[r_idx] <= r_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_bus_target
// Purpose  : Directed self-checking bench for cpu_bus_target.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_target;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] IDV  = 32'h6583_2001;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cpu_bus_target_if u_if0 ();
    cpu_bus_target_if u_if1 ();

    cpu_bus_target #(
        .BASE_ADDR   (BASE),
        .ADDR_LSB    (0),
        .WAIT_STATES (2),
        .ID_VALUE    (IDV)
    ) u_dut0 (
        .i_cpu_clk (clk),
        .i_rst_n   (rst_n),
        .bus       (u_if0)
    );

    cpu_bus_target #(
        .BASE_ADDR   (BASE),
        .ADDR_LSB    (0),
        .WAIT_STATES (0),
        .ID_VALUE    (IDV)
    ) u_dut1 (
        .i_cpu_clk (clk),
        .i_rst_n   (rst_n),
        .bus       (u_if1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int dut, input logic stb, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
        if (dut == 0) begin
            u_if0.i_bus_clk = stb; u_if0.i_bus_we = we;
            u_if0.i_bus_addr = addr; u_if0.i_bus_data = data;
        end else begin
            u_if1.i_bus_clk = stb; u_if1.i_bus_we = we;
            u_if1.i_bus_addr = addr; u_if1.i_bus_data = data;
        end
    endtask

    function automatic logic get_ready(input int dut);
        return (dut == 0) ? u_if0.o_bus_data_ready : u_if1.o_bus_data_ready;
    endfunction

    function automatic logic [31:0] get_data(input int dut);
        return (dut == 0) ? u_if0.o_bus_data : u_if1.o_bus_data;
    endfunction

    // One full handshake; lat counts edges after the accepting edge, -1 on timeout.
    task automatic xfer(input int dut, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output int lat, output logic rdy_after);
        lat = -1;
        drive(dut, 1'b1, we, addr, wdata);
        for (int n = 0; n < 40; n++) begin
            tick();
            if (get_ready(dut) === 1'b1) begin
                lat = n;
                break;
            end
        end
        rdata = get_data(dut);
        drive(dut, 1'b0, we, addr, wdata);
        tick();
        rdy_after = get_ready(dut);
    endtask

    task automatic apply_reset();
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        checks++; if (u_if0.o_bus_data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", u_if0.o_bus_data_ready); end
        checks++; if (u_if0.o_bus_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", u_if0.o_bus_data); end
        checks++; if (u_if0.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", u_if0.o_busy); end
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (u_if0.o_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", u_if0.o_busy); end
        checks++; if (u_if1.o_bus_data_ready !== 1'b0) begin errors++; $display("FAIL post_reset_ready1: got %b expected 0", u_if1.o_bus_data_ready); end
    endtask

    task automatic test_read_id();
        logic [31:0] rd; int lat; logic ra;
        xfer(0, 1'b0, BASE, 32'd0, rd, lat, ra);
        checks++; if (lat !== 3) begin errors++; $display("FAIL read_id_latency: got %0d expected 3", lat); end
        checks++; if (rd !== IDV) begin errors++; $display("FAIL read_id_data: got %h expected %h", rd, IDV); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL read_id_ready_drop: got %b expected 0", ra); end
    endtask

    task automatic test_rw_scratch();
        logic [31:0] rd; int lat; logic ra;
        apply_reset();
        xfer(0, 1'b1, BASE + 32'd1, 32'hDEAD_BEEF, rd, lat, ra);
        checks++; if (lat !== 3) begin errors++; $display("FAIL write_latency: got %0d expected 3", lat); end
        xfer(0, 1'b0, BASE + 32'd1, 32'd0, rd, lat, ra);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL scratch_readback: got %h expected deadbeef", rd); end
        xfer(0, 1'b1, BASE, 32'h1234_5678, rd, lat, ra);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_keeps_rdata: got %h expected deadbeef", rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL ro_write_ack: got %0d expected 3", lat); end
        xfer(0, 1'b0, BASE, 32'd0, rd, lat, ra);
        checks++; if (rd !== IDV) begin errors++; $display("FAIL id_readonly: got %h expected %h", rd, IDV); end
        xfer(0, 1'b0, BASE + 32'd3, 32'd0, rd, lat, ra);
        checks++; if (rd !== 32'd4) begin errors++; $display("FAIL xfers_after_4: got %0d expected 4", rd); end
    endtask

    task automatic test_miss();
        logic [31:0] rd; int lat; logic ra; logic seen_rdy; logic seen_busy;
        seen_rdy = 1'b0; seen_busy = 1'b0;
        drive(0, 1'b1, 1'b0, BASE + 32'h100, 32'd0);
        for (int n = 0; n < 20; n++) begin
            tick();
            if (u_if0.o_bus_data_ready !== 1'b0) seen_rdy = 1'b1;
            if (u_if0.o_busy !== 1'b0) seen_busy = 1'b1;
        end
        drive(0, 1'b0, 1'b0, BASE + 32'h100, 32'd0);
        tick();
        checks++; if (seen_rdy !== 1'b0) begin errors++; $display("FAIL miss_ready: got %b expected 0", seen_rdy); end
        checks++; if (seen_busy !== 1'b0) begin errors++; $display("FAIL miss_busy: got %b expected 0", seen_busy); end
        xfer(0, 1'b0, BASE + 32'd3, 32'd0, rd, lat, ra);
        checks++; if (rd !== 32'd5) begin errors++; $display("FAIL miss_xfers: got %0d expected 5", rd); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; int lat; logic ra; logic seen_rdy;
        seen_rdy = 1'b0;
        drive(0, 1'b1, 1'b1, BASE + 32'd5, 32'hA5A5_A5A5);
        tick();
        tick();
        drive(0, 1'b0, 1'b1, BASE + 32'd5, 32'hA5A5_A5A5);
        for (int n = 0; n < 6; n++) begin
            tick();
            if (u_if0.o_bus_data_ready !== 1'b0) seen_rdy = 1'b1;
        end
        checks++; if (seen_rdy !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", seen_rdy); end
        checks++; if (u_if0.o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", u_if0.o_busy); end
        xfer(0, 1'b0, BASE + 32'd5, 32'd0, rd, lat, ra);
        checks++; if (lat !== 3) begin errors++; $display("FAIL abort_next_latency: got %0d expected 3", lat); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL abort_no_write: got %h expected 00000000", rd); end
        xfer(0, 1'b0, BASE + 32'd3, 32'd0, rd, lat, ra);
        checks++; if (rd !== 32'd7) begin errors++; $display("FAIL abort_xfers: got %0d expected 7", rd); end
    endtask

    task automatic test_xfers_write();
        logic [31:0] rd; int lat; logic ra;
        xfer(0, 1'b1, BASE + 32'd3, 32'h0000_0055, rd, lat, ra);
        checks++; if (lat !== 3) begin errors++; $display("FAIL xfers_write_ack: got %0d expected 3", lat); end
        xfer(0, 1'b0, BASE + 32'd3, 32'd0, rd, lat, ra);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL xfers_write_wins: got %0d expected 0", rd); end
        xfer(0, 1'b0, BASE + 32'd3, 32'd0, rd, lat, ra);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL xfers_after_clear: got %0d expected 1", rd); end
    endtask

    task automatic test_gp();
        logic [31:0] rd; int lat; logic ra;
        xfer(0, 1'b1, BASE + 32'd4,  32'h0F0F_0F0F, rd, lat, ra);
        xfer(0, 1'b1, BASE + 32'd15, 32'hCAFE_0015, rd, lat, ra);
        xfer(0, 1'b0, BASE + 32'd14, 32'd0, rd, lat, ra);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL gp14_untouched: got %h expected 00000000", rd); end
        xfer(0, 1'b0, BASE + 32'd4, 32'd0, rd, lat, ra);
        checks++; if (rd !== 32'h0F0F_0F0F) begin errors++; $display("FAIL gp4_readback: got %h expected 0f0f0f0f", rd); end
        xfer(0, 1'b0, BASE + 32'd15, 32'd0, rd, lat, ra);
        checks++; if (rd !== 32'hCAFE_0015) begin errors++; $display("FAIL gp15_readback: got %h expected cafe0015", rd); end
    endtask

    task automatic test_cycles_ws0();
        logic [31:0] c1; logic [31:0] c2; int lat; logic ra;
        xfer(1, 1'b0, BASE + 32'd2, 32'd0, c1, lat, ra);
        checks++; if (lat !== 1) begin errors++; $display("FAIL ws0_latency: got %0d expected 1", lat); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL ws0_ready_drop: got %b expected 0", ra); end
        repeat (10) tick();
        xfer(1, 1'b0, BASE + 32'd2, 32'd0, c2, lat, ra);
        checks++; if ((c2 - c1) !== 32'd13) begin errors++; $display("FAIL cycles_delta: got %0d expected 13", c2 - c1); end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd; int lat; logic ra; logic seen;
        seen = 1'b0;
        drive(0, 1'b1, 1'b0, BASE + 32'd4, 32'd0);
        tick();
        tick();
        checks++; if (u_if0.o_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %b expected 1", u_if0.o_busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (u_if0.o_bus_data_ready !== 1'b0) begin errors++; $display("FAIL async_ready: got %b expected 0", u_if0.o_bus_data_ready); end
        checks++; if (u_if0.o_bus_data !== 32'd0) begin errors++; $display("FAIL async_data: got %h expected 00000000", u_if0.o_bus_data); end
        checks++; if (u_if0.o_busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b expected 0", u_if0.o_busy); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            if ((u_if0.o_busy !== 1'b0) || (u_if0.o_bus_data_ready !== 1'b0)) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL high_at_release: got %b expected 0", seen); end
        drive(0, 1'b0, 1'b0, BASE + 32'd4, 32'd0);
        tick();
        xfer(0, 1'b0, BASE + 32'd3, 32'd0, rd, lat, ra);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_xfers: got %0d expected 0", rd); end
        xfer(0, 1'b0, BASE + 32'd4, 32'd0, rd, lat, ra);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_gp4: got %h expected 00000000", rd); end
        xfer(0, 1'b0, BASE + 32'd1, 32'd0, rd, lat, ra);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_scratch: got %h expected 00000000", rd); end
    endtask

    initial begin
        test_reset();
        test_read_id();
        test_rw_scratch();
        test_miss();
        test_abort();
        test_xfers_write();
        test_gp();
        test_cycles_ws0();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
